// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 16-bit CPU control path.
//   opcode_t  - 4-bit instruction opcodes (OP_ADD .. OP_NOP)
//   ALU_*     - ALU operation select codes
//   *_MSB/LSB - bit positions of the instruction word fields
//   ctrl_t    - bundle of decoded control outputs
package cpu_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'b0000,
      OP_SUB  = 4'b0001,
      OP_AND  = 4'b0010,
      OP_OR   = 4'b0011,
      OP_XOR  = 4'b0100,
      OP_NOT  = 4'b0101,
      OP_SHL  = 4'b0110,
      OP_SHR  = 4'b0111,
      OP_LOAD = 4'b1000,
      OP_RSV9 = 4'b1001,
      OP_RSVA = 4'b1010,
      OP_RSVB = 4'b1011,
      OP_JMP  = 4'b1100,
      OP_INC  = 4'b1101,
      OP_DEC  = 4'b1110,
      OP_NOP  = 4'b1111
   } opcode_t;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_NOT  = 4'b0101;
   localparam logic [3:0] ALU_SHL  = 4'b0110;
   localparam logic [3:0] ALU_SHR  = 4'b0111;
   localparam logic [3:0] ALU_INC  = 4'b1000;
   localparam logic [3:0] ALU_DEC  = 4'b1001;
   localparam logic [3:0] ALU_PASS = 4'b1111;

   localparam int unsigned OPC_MSB = 15;
   localparam int unsigned OPC_LSB = 12;
   localparam int unsigned R1_MSB  = 11;
   localparam int unsigned R1_LSB  = 10;
   localparam int unsigned R2_MSB  = 9;
   localparam int unsigned R2_LSB  = 8;
   localparam int unsigned ADR_MSB = 7;
   localparam int unsigned ADR_LSB = 0;

   typedef struct packed {
      logic [3:0] alu_code;
      logic       ram_read;
      logic       reg_read;
      logic       reg_write;
      logic       pc_jump;
   } ctrl_t;

endpackage

// File: rtl/cpu_control_unit_if.sv
// cpu_control_unit_if: instruction in / decoded control out.
//   instruction - 16-bit instruction word {opcode, reg1, reg2, addr}
//   alu_code, RAM_read, Reg_read, Reg_write, pc_jump - control strobes
//   reg1, reg2, RAM_adr - raw instruction fields, registered
// master: fetch/datapath side; slave: the control unit.
interface cpu_control_unit_if;

   logic [15:0] instruction;
   logic [3:0]  alu_code;
   logic        RAM_read;
   logic        Reg_read;
   logic        Reg_write;
   logic        pc_jump;
   logic [1:0]  reg1;
   logic [1:0]  reg2;
   logic [7:0]  RAM_adr;

   modport master (
      output instruction,
      input  alu_code, RAM_read, Reg_read, Reg_write, pc_jump, reg1, reg2, RAM_adr
   );

   modport slave (
      input  instruction,
      output alu_code, RAM_read, Reg_read, Reg_write, pc_jump, reg1, reg2, RAM_adr
   );

endinterface

// File: rtl/cpu_control_unit_instr_decode.sv
// instr_decode: combinational opcode-to-control table.
//   i_opcode - instruction[15:12]
//   o_ctrl   - alu_code and RAM/register/PC strobes
// Reserved opcodes and NOP fall through to the all-zero default.
module instr_decode
   import cpu_pkg::*;
(
   input  logic [3:0] i_opcode,
   output ctrl_t      o_ctrl
);

   always_comb begin
      o_ctrl = '0;
      case (opcode_t'(i_opcode))
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR: begin
            // ALU op codes share the opcode encoding
            o_ctrl.alu_code  = i_opcode;
            o_ctrl.reg_read  = 1'b1;
            o_ctrl.reg_write = 1'b1;
         end
         OP_LOAD: begin
            o_ctrl.alu_code  = ALU_PASS;
            o_ctrl.ram_read  = 1'b1;
            o_ctrl.reg_write = 1'b1;
         end
         OP_JMP: begin
            o_ctrl.pc_jump = 1'b1;
         end
         OP_INC: begin
            o_ctrl.alu_code  = ALU_INC;
            o_ctrl.reg_read  = 1'b1;
            o_ctrl.reg_write = 1'b1;
         end
         OP_DEC: begin
            o_ctrl.alu_code  = ALU_DEC;
            o_ctrl.reg_read  = 1'b1;
            o_ctrl.reg_write = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/cpu_control_unit.sv
// cpu_control_unit: registered instruction decoder, one cycle latency.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, clears every output
//   bus   - slave side of cpu_control_unit_if (instruction in, controls out)
module cpu_control_unit
   import cpu_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   cpu_control_unit_if.slave     bus
);

   ctrl_t      w_ctrl;
   ctrl_t      r_ctrl;
   logic [1:0] r_reg1;
   logic [1:0] r_reg2;
   logic [7:0] r_adr;

   instr_decode u_decode (
      .i_opcode (bus.instruction[OPC_MSB:OPC_LSB]),
      .o_ctrl   (w_ctrl)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ctrl <= '0;
         r_reg1 <= '0;
         r_reg2 <= '0;
         r_adr  <= '0;
      end else begin
         r_ctrl <= w_ctrl;
         r_reg1 <= bus.instruction[R1_MSB:R1_LSB];
         r_reg2 <= bus.instruction[R2_MSB:R2_LSB];
         r_adr  <= bus.instruction[ADR_MSB:ADR_LSB];
      end
   end

   assign bus.alu_code  = r_ctrl.alu_code;
   assign bus.RAM_read  = r_ctrl.ram_read;
   assign bus.Reg_read  = r_ctrl.reg_read;
   assign bus.Reg_write = r_ctrl.reg_write;
   assign bus.pc_jump   = r_ctrl.pc_jump;
   assign bus.reg1      = r_reg1;
   assign bus.reg2      = r_reg2;
   assign bus.RAM_adr   = r_adr;

endmodule

// File: tb/tb_cpu_control_unit.sv
// tb_cpu_control_unit: scoreboard bench for cpu_control_unit.
// Driver issues one instruction per falling edge and queues the expected
// outputs; the monitor pops and compares after every rising edge.
// Output compare word: {alu_code, RAM_read, Reg_read, Reg_write, pc_jump,
// reg1, reg2, RAM_adr}.
module tb_cpu_control_unit;

   logic clk;
   logic rst_n;

   cpu_control_unit_if bus ();

   cpu_control_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [15:0] instr;
      logic [3:0]  alu;
      logic [3:0]  ctl;   // {RAM_read, Reg_read, Reg_write, pc_jump}
      string       name;
   } vec_t;

   typedef struct {
      logic [19:0] exp;
      string       name;
   } exp_t;

   exp_t  sb_q[$];
   vec_t  vecs[$];
   int    checks = 0;
   int    errors = 0;
   bit    mon_en = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [19:0] actual();
      return {bus.alu_code, bus.RAM_read, bus.Reg_read, bus.Reg_write,
              bus.pc_jump, bus.reg1, bus.reg2, bus.RAM_adr};
   endfunction

   function automatic logic [19:0] mk_exp(logic [3:0] alu, logic [3:0] ctl,
                                          logic [15:0] instr);
      return {alu, ctl, instr[11:0]};
   endfunction

   task automatic check(string name, logic [19:0] act, logic [19:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %05h expected %05h", name, act, exp);
      end
   endtask

   // monitor
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (mon_en && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.name, actual(), e.exp);
         end
      end
   end

   initial begin
      exp_t e;
      vecs.push_back('{16'b0000_11_01_00000000, 4'b0000, 4'b0110, "ADD"});
      vecs.push_back('{16'b0010_01_11_00000000, 4'b0010, 4'b0110, "AND"});
      vecs.push_back('{16'b1000_00_00_00000100, 4'b1111, 4'b1010, "LOAD"});
      vecs.push_back('{16'b1100_00_00_00101010, 4'b0000, 4'b0001, "JMP"});
      vecs.push_back('{16'b1101_10_00_00000000, 4'b1000, 4'b0110, "INC"});
      vecs.push_back('{16'b1110_11_00_00000000, 4'b1001, 4'b0110, "DEC"});
      vecs.push_back('{16'b1001_01_10_11001100, 4'b0000, 4'b0000, "RSV9"});
      vecs.push_back('{16'b1011_10_01_01010101, 4'b0000, 4'b0000, "RSVB"});
      vecs.push_back('{16'b1111_11_11_11111111, 4'b0000, 4'b0000, "NOP"});
      vecs.push_back('{16'b1010_00_11_00000001, 4'b0000, 4'b0000, "RSVA"});
      vecs.push_back('{16'b0001_10_11_10000001, 4'b0001, 4'b0110, "SUB"});
      vecs.push_back('{16'b0011_01_01_00001111, 4'b0011, 4'b0110, "OR"});
      vecs.push_back('{16'b0101_00_01_00000011, 4'b0101, 4'b0110, "NOT"});
      vecs.push_back('{16'b0110_11_10_11110000, 4'b0110, 4'b0110, "SHL"});
      vecs.push_back('{16'b0111_01_00_10000000, 4'b0111, 4'b0110, "SHR"});
      vecs.push_back('{16'b1000_11_10_11111110, 4'b1111, 4'b1010, "LOAD2"});
      vecs.push_back('{16'b1100_01_01_00000001, 4'b0000, 4'b0001, "JMP2"});
      vecs.push_back('{16'b1111_00_00_00000000, 4'b0000, 4'b0000, "NOP2"});

      // reset held with an instruction present
      rst_n = 1'b0;
      bus.instruction = 16'h4800;
      repeat (3) @(posedge clk);
      #1;
      check("reset_hold", actual(), 20'h0_0_000);

      @(negedge clk);
      mon_en = 1;
      rst_n  = 1'b1;
      e.exp  = 20'h4_6_800;   // XOR, Reg_read/Reg_write, reg1=10
      e.name = "first_after_reset";
      sb_q.push_back(e);

      foreach (vecs[i]) begin
         @(negedge clk);
         bus.instruction = vecs[i].instr;
         e.exp  = mk_exp(vecs[i].alu, vecs[i].ctl, vecs[i].instr);
         e.name = vecs[i].name;
         sb_q.push_back(e);
      end

      for (int k = 0; k < 50 && sb_q.size() != 0; k++) @(posedge clk);
      #2;
      if (sb_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending expected 0", sb_q.size());
      end
      mon_en = 0;

      // latency: mid-cycle change is not visible before the next edge
      @(negedge clk);
      bus.instruction = 16'b0100_01_10_00010001;
      @(posedge clk);
      #1;
      check("lat_xor", actual(), 20'h4_6_611);
      #3;
      bus.instruction = 16'b1100_00_00_11110000;
      #2;
      check("lat_hold", actual(), 20'h4_6_611);
      @(posedge clk);
      #1;
      check("lat_jmp", actual(), 20'h0_1_0F0);

      // async reset pulse between edges
      #2;
      rst_n = 1'b0;
      #1;
      check("async_clear", actual(), 20'h0_0_000);
      #1;
      rst_n = 1'b1;
      #1;
      check("clear_until_edge", actual(), 20'h0_0_000);
      @(posedge clk);
      #1;
      check("after_pulse", actual(), 20'h0_1_0F0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
